run_splitter: RTL and testbench

// - Feeds the MERGER stage from the opposite end: pops one key stream from a

---
 rtl/bonsai_pkg.sv | 10 +
 rtl/run_splitter_if.sv | 24 ++
 rtl/run_splitter.sv | 102 ++++++++++
 tb/tb_run_splitter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bonsai_pkg.sv
// Shared definitions for the bonsai sort pipeline (run splitter and merger).
package bonsai_pkg;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned TERMINATOR = 0;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_TERM2 = 1'b1
  } split_state_t;
endpackage

// File: rtl/run_splitter_if.sv
// Input FIFO pop port plus the two output FIFO write ports of the run splitter.
interface run_splitter_if #(
  parameter int unsigned WIDTH = bonsai_pkg::WIDTH
);
  logic [WIDTH-1:0] i_fifo_in;
  logic             i_fifo_in_empty;
  logic             o_fifo_in_read;
  logic             i_fifo_1_ready;
  logic             o_fifo_1_write;
  logic [WIDTH-1:0] o_data_1;
  logic             i_fifo_2_ready;
  logic             o_fifo_2_write;
  logic [WIDTH-1:0] o_data_2;

  modport master (
    input  i_fifo_in, i_fifo_in_empty, i_fifo_1_ready, i_fifo_2_ready,
    output o_fifo_in_read, o_fifo_1_write, o_data_1, o_fifo_2_write, o_data_2
  );

  modport slave (
    output i_fifo_in, i_fifo_in_empty, i_fifo_1_ready, i_fifo_2_ready,
    input  o_fifo_in_read, o_fifo_1_write, o_data_1, o_fifo_2_write, o_data_2
  );
endinterface

// File: rtl/run_splitter.sv
// Splits a terminated key stream into ascending runs, alternating them between
// two output FIFOs; the terminator is copied to output 1 and then output 2.
module run_splitter
  import bonsai_pkg::*;
#(
  parameter int unsigned WIDTH   = bonsai_pkg::WIDTH,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  run_splitter_if.master     bus,
  output logic [COUNT_W-1:0] o_run_count,
  output logic               o_stream_done
);

  split_state_t     r_state, w_next_state;
  logic             r_dest;    // 0 selects output 1, 1 selects output 2
  logic             r_first;
  logic [WIDTH-1:0] r_prev;

  logic [WIDTH-1:0] w_key;
  logic             w_is_term;
  logic             w_tgt;
  logic             w_tgt_ready;
  logic             w_adv;
  logic             w_term_done;

  assign w_key       = bus.i_fifo_in;
  assign w_is_term   = (w_key == WIDTH'(TERMINATOR));
  assign w_tgt       = (r_first || (w_key >= r_prev)) ? r_dest : ~r_dest;
  assign w_tgt_ready = w_tgt ? bus.i_fifo_2_ready : bus.i_fifo_1_ready;

  assign bus.o_data_1 = (r_state == S_RUN) ? w_key : '0;
  assign bus.o_data_2 = (r_state == S_RUN) ? w_key : '0;

  always_comb begin
    w_next_state       = r_state;
    bus.o_fifo_in_read = 1'b0;
    bus.o_fifo_1_write = 1'b0;
    bus.o_fifo_2_write = 1'b0;
    w_adv              = 1'b0;
    w_term_done        = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        S_RUN: begin
          if (!bus.i_fifo_in_empty) begin
            if (w_is_term) begin
              if (bus.i_fifo_1_ready) begin
                bus.o_fifo_in_read = 1'b1;
                bus.o_fifo_1_write = 1'b1;
                w_next_state       = S_TERM2;
              end
            end else if (w_tgt_ready) begin
              bus.o_fifo_in_read = 1'b1;
              bus.o_fifo_1_write = ~w_tgt;
              bus.o_fifo_2_write = w_tgt;
              w_adv              = 1'b1;
            end
          end
        end
        S_TERM2: begin
          if (bus.i_fifo_2_ready) begin
            bus.o_fifo_2_write = 1'b1;
            w_term_done        = 1'b1;
            w_next_state       = S_RUN;
          end
        end
        default: w_next_state = S_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_RUN;
      r_dest        <= 1'b0;
      r_first       <= 1'b1;
      r_prev        <= '0;
      o_run_count   <= '0;
      o_stream_done <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      o_stream_done <= w_term_done;
      if (w_adv) begin
        r_prev  <= w_key;
        r_dest  <= w_tgt;
        r_first <= 1'b0;
        // First key of a stream restarts the count; a destination flip starts a new run.
        if (r_first) begin
          o_run_count <= COUNT_W'(1);
        end else if ((w_tgt != r_dest) && (o_run_count != '1)) begin
          o_run_count <= o_run_count + 1'b1;
        end
      end
      if (w_term_done) begin
        r_dest  <= 1'b0;
        r_first <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_splitter.sv
// Directed bench for run_splitter: queue-based stream model checked every cycle,
// plus literal per-scenario expectations on the captured output lists.
module tb_run_splitter;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] run_count;
  logic          stream_done;

  always #5 clk = ~clk;

  run_splitter_if #(.WIDTH(W)) bus ();

  run_splitter #(.WIDTH(W), .COUNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_run_count   (run_count),
    .o_stream_done (stream_done)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] in_q[$];
  logic [W-1:0] exp1[$], exp2[$], cap1[$], cap2[$];
  int           exp_cnt[$];
  int           cnt_log[$];
  int           done_pulses = 0;
  bit           rd_s = 1'b0;
  bit           prev_t2 = 1'b0;

  // Stream model state: runs counted by descents, alternating sides.
  bit           m_started = 1'b0;
  logic [W-1:0] m_prev = '0;
  int           m_side = 0;
  int           m_runs = 0;
  int           m_last = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_key(input logic [W-1:0] k);
    if (k == 0) begin
      exp1.push_back('0);
      exp2.push_back('0);
      if (m_started) m_last = m_runs;
      exp_cnt.push_back(m_last);
      m_started = 1'b0;
    end else begin
      if (!m_started) begin
        m_started = 1'b1;
        m_runs    = 1;
        m_side    = 0;
      end else if (k < m_prev) begin
        m_runs++;
        m_side = 1 - m_side;
      end
      m_prev = k;
      if (m_side == 0) exp1.push_back(k);
      else             exp2.push_back(k);
    end
  endfunction

  function automatic void refresh();
    bus.i_fifo_in_empty = (in_q.size() == 0);
    bus.i_fifo_in       = (in_q.size() != 0) ? in_q[0] : '0;
  endfunction

  task automatic push(input logic [W-1:0] ks[$]);
    foreach (ks[i]) begin
      in_q.push_back(ks[i]);
      model_key(ks[i]);
    end
    refresh();
  endtask

  task automatic chk_list(input string name, input logic [W-1:0] act[$], input logic [W-1:0] exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    foreach (exp[i]) if (i < act.size()) chk(name, act[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int n);
    int cyc = 0;
    while (done_pulses < n && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("done_timeout", (done_pulses >= n), 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rd_s && in_q.size() != 0) void'(in_q.pop_front());
    refresh();
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_quiet", {bus.o_fifo_in_read, bus.o_fifo_1_write, bus.o_fifo_2_write}, 0);
      rd_s    = 1'b0;
      prev_t2 = 1'b0;
    end else begin
      chk("read_when_empty", (bus.o_fifo_in_read && bus.i_fifo_in_empty), 0);
      chk("both_writes", (bus.o_fifo_1_write && bus.o_fifo_2_write), 0);
      chk("stream_done", stream_done, prev_t2);
      if (bus.o_fifo_1_write) begin
        cap1.push_back(bus.o_data_1);
        if (exp1.size() == 0) chk("out1_unexpected", bus.o_data_1, -1);
        else                  chk("out1", bus.o_data_1, exp1.pop_front());
      end
      if (bus.o_fifo_2_write) begin
        cap2.push_back(bus.o_data_2);
        if (exp2.size() == 0) chk("out2_unexpected", bus.o_data_2, -1);
        else                  chk("out2", bus.o_data_2, exp2.pop_front());
      end
      if (stream_done) begin
        done_pulses++;
        cnt_log.push_back(run_count);
        if (exp_cnt.size() == 0) chk("run_count_unexpected", run_count, -1);
        else                     chk("run_count", run_count, exp_cnt.pop_front());
      end
      prev_t2 = bus.o_fifo_2_write && (bus.o_data_2 == 0);
      rd_s    = bus.o_fifo_in_read;
    end
  end

  initial begin
    logic [W-1:0] s[$];
    logic [W-1:0] l1[$];
    logic [W-1:0] l2[$];
    logic [W-1:0] rq[$];
    bus.i_fifo_1_ready = 1'b1;
    bus.i_fifo_2_ready = 1'b1;
    refresh();
    repeat (3) tick();
    chk("reset_count", run_count, 0);
    chk("reset_done", stream_done, 0);
    rst = 1'b0;
    tick();

    // 1: single ascending run
    s = '{1, 3, 5, 0}; push(s);
    wait_done(1);
    l1 = '{1, 3, 5, 0}; l2 = '{0};
    chk_list("t1_out1", cap1, l1); chk_list("t1_out2", cap2, l2);
    chk("t1_count", run_count, 1);
    cap1.delete(); cap2.delete(); tick();

    // 2: three runs
    s = '{4, 7, 2, 9, 1, 0}; push(s);
    wait_done(2);
    l1 = '{4, 7, 1, 0}; l2 = '{2, 9, 0};
    chk_list("t2_out1", cap1, l1); chk_list("t2_out2", cap2, l2);
    chk("t2_count", run_count, 3);
    cap1.delete(); cap2.delete(); tick();

    // 3: equal keys continue a run
    s = '{5, 5, 3, 0}; push(s);
    wait_done(3);
    l1 = '{5, 5, 0}; l2 = '{3, 0};
    chk_list("t3_out1", cap1, l1); chk_list("t3_out2", cap2, l2);
    chk("t3_count", run_count, 2);
    cap1.delete(); cap2.delete(); tick();

    // 4: output 2 stalls at key 2
    bus.i_fifo_2_ready = 1'b0;
    s = '{1, 3, 2, 0}; push(s);
    for (int c = 0; c < 50 && cap1.size() < 2; c++) tick();
    chk("t4_pre_stall", cap1.size(), 2);
    for (int c = 0; c < 5; c++) begin
      chk("t4_stall_read", bus.o_fifo_in_read, 0);
      chk("t4_stall_write", bus.o_fifo_1_write | bus.o_fifo_2_write, 0);
      tick();
    end
    bus.i_fifo_2_ready = 1'b1;
    #1;
    chk("t4_resume_write", bus.o_fifo_2_write, 1);
    chk("t4_resume_data", bus.o_data_2, 2);
    wait_done(4);
    l1 = '{1, 3, 0}; l2 = '{2, 0};
    chk_list("t4_out1", cap1, l1); chk_list("t4_out2", cap2, l2);
    cap1.delete(); cap2.delete(); cnt_log.delete(); tick();

    // 5: back-to-back streams
    s = '{8, 6, 0, 2, 4, 0}; push(s);
    wait_done(6);
    l1 = '{8, 0, 2, 4, 0}; l2 = '{6, 0, 0};
    chk_list("t5_out1", cap1, l1); chk_list("t5_out2", cap2, l2);
    chk("t5_cnt_pulses", cnt_log.size(), 2);
    if (cnt_log.size() == 2) begin
      chk("t5_cnt_first", cnt_log[0], 2);
      chk("t5_cnt_second", cnt_log[1], 1);
    end
    cap1.delete(); cap2.delete(); tick();

    // 6: reset after key 7 abandons the stream
    s = '{1, 7, 3, 0}; push(s);
    for (int c = 0; c < 50 && cap1.size() < 2; c++) tick();
    chk("t6_pre_reset", cap1.size(), 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_drop", {bus.o_fifo_in_read, bus.o_fifo_1_write, bus.o_fifo_2_write}, 0);
    tick(); tick();
    chk("t6_rst_count", run_count, 0);
    exp1.delete(); exp2.delete(); exp_cnt.delete();
    m_started = 1'b0; m_last = 0;
    rq = in_q;
    foreach (rq[i]) model_key(rq[i]);
    rst = 1'b0;
    wait_done(7);
    l1 = '{1, 7, 3, 0}; l2 = '{0};
    chk_list("t6_out1", cap1, l1); chk_list("t6_out2", cap2, l2);
    chk("t6_count", run_count, 1);
    cap1.delete(); cap2.delete(); tick();

    // 7: empty stream keeps the previous count
    s = '{0}; push(s);
    wait_done(8);
    l1 = '{0}; l2 = '{0};
    chk_list("t7_out1", cap1, l1); chk_list("t7_out2", cap2, l2);
    chk("t7_count", run_count, 1);
    repeat (3) tick();
    chk("leftover_exp", exp1.size() + exp2.size() + exp_cnt.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
